// File: rtl/wall_scheduler.sv
// wall_scheduler: paces wall launches from frame ticks, hands out launches
// round-robin to ready wall slots, keeps score and latches game-over.
// Optional feature macro: WALL_SCHED_SPEEDUP_EN (score-driven launch speed-up).
module wall_scheduler #(
    parameter int NUM_WALLS    = 4,
    parameter int SPAWN_PERIOD = 60,
    parameter int SCORE_W      = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 frame_tick,
    input  logic [NUM_WALLS-1:0] wall_ready,
    input  logic [NUM_WALLS-1:0] wall_passed,
    input  logic [NUM_WALLS-1:0] wall_touched,
    output logic [NUM_WALLS-1:0] go,
    output logic                 game_over,
    output logic [SCORE_W-1:0]   score,
    output logic                 active
);

    localparam int CNT_W = $clog2(SPAWN_PERIOD + 1);
    localparam int PTR_W = $clog2(NUM_WALLS);
    localparam int SMAX  = (1 << SCORE_W) - 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_COUNT = 2'd1,
        S_SPAWN = 2'd2,
        S_OVER  = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [PTR_W-1:0]     ptr_q, ptr_d;
    logic [NUM_WALLS-1:0] go_q, go_d;
    logic [SCORE_W-1:0]   score_q, score_d;
    logic                 game_over_q, game_over_d;
    logic                 active_q, active_d;
    logic [CNT_W-1:0]     reload_w;
    logic                 hit;
    logic                 touch;
    logic                 live;

    // Slot index (p + j) wrapped into 0..NUM_WALLS-1.
    function automatic logic [PTR_W-1:0] wrap_idx(input int p, input int j);
        return PTR_W'((p + j) % NUM_WALLS);
    endfunction

    // Number of walls cleared in this cycle.
    function automatic int popcount_f(input logic [NUM_WALLS-1:0] v);
        int c;
        c = 0;
        for (int i = 0; i < NUM_WALLS; i++) begin
            if (v[i]) c = c + 1;
        end
        return c;
    endfunction

    // Score addition clamped at the all-ones value.
    function automatic logic [SCORE_W-1:0] sat_add_f(input logic [SCORE_W-1:0] s, input int n);
        int t;
        t = int'(s) + n;
        if (t > SMAX) return SCORE_W'(SMAX);
        return SCORE_W'(t);
    endfunction

`ifdef WALL_SCHED_SPEEDUP_EN
    // One frame faster per 8 points, never below half the base period.
    function automatic logic [CNT_W-1:0] reload_f(input logic [SCORE_W-1:0] s);
        int dec;
        dec = int'(s >> 3);
        if (dec > SPAWN_PERIOD - SPAWN_PERIOD / 2) return CNT_W'(SPAWN_PERIOD / 2);
        return CNT_W'(SPAWN_PERIOD - dec);
    endfunction

    // Launch interval follows the current score.
    always_comb reload_w = reload_f(score_q);
`else
    // Fixed launch interval.
    always_comb reload_w = CNT_W'(SPAWN_PERIOD);
`endif

    // Next-state, launch selection and score update.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        score_d = score_q;
        go_d    = '0;
        hit     = 1'b0;
        touch   = |wall_touched;
        live    = (state_q == S_COUNT) || (state_q == S_SPAWN);

        case (state_q)
            S_IDLE: begin
                if (enable) begin
                    state_d = S_SPAWN;
                    score_d = '0;
                    ptr_d   = '0;
                end
            end
            S_SPAWN: begin
                if (!enable) begin
                    state_d = S_IDLE;
                end else if (touch) begin
                    state_d = S_OVER;
                end else begin
                    // First ready slot at or after the pointer wins; none ready
                    // means this launch is simply skipped.
                    for (int j = 0; j < NUM_WALLS; j++) begin
                        if (!hit && wall_ready[wrap_idx(int'(ptr_q), j)]) begin
                            hit = 1'b1;
                            go_d[wrap_idx(int'(ptr_q), j)] = 1'b1;
                            ptr_d = wrap_idx(int'(ptr_q), j + 1);
                        end
                    end
                    cnt_d   = reload_w;
                    state_d = S_COUNT;
                end
            end
            S_COUNT: begin
                if (!enable) begin
                    state_d = S_IDLE;
                end else if (touch) begin
                    state_d = S_OVER;
                end else if (frame_tick) begin
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) state_d = S_SPAWN;
                end
            end
            S_OVER: begin
                if (!enable) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // A collision in the same cycle cancels that cycle's passes.
        if (live && enable && !touch) begin
            score_d = sat_add_f(score_q, popcount_f(wall_passed));
        end

        game_over_d = (state_d == S_OVER);
        active_d    = (state_d == S_COUNT) || (state_d == S_SPAWN);
    end

    // State and output registers; reset clears everything at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            ptr_q       <= '0;
            go_q        <= '0;
            score_q     <= '0;
            game_over_q <= 1'b0;
            active_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ptr_q       <= ptr_d;
            go_q        <= go_d;
            score_q     <= score_d;
            game_over_q <= game_over_d;
            active_q    <= active_d;
        end
    end

    assign go        = go_q;
    assign game_over = game_over_q;
    assign score     = score_q;
    assign active    = active_q;

endmodule

// File: doc/wall_scheduler.md
# wall_scheduler

Game-level sequencer for a bank of `NUM_WALLS` wall controllers. It paces wall launches from a frame-tick timer and picks a free wall slot round-robin. It issues a one-cycle `go` to that slot, counts walls the player clears, and latches game-over on any collision. It sits between the top-level game FSM (`enable`, `frame_tick`) and the per-wall controllers (`wall_ready`, `wall_passed`, `wall_touched`).

## Interface
- `NUM_WALLS`, 4: number of wall controller slots (2..8).
- `SPAWN_PERIOD`, 60: frame ticks between launch attempts (>= 4).
- `SCORE_W`, 8: score counter width.

- `clk` in 1: system clock; all state on rising edge.
- `reset` in 1: asynchronous, active-high; clears all state immediately.
- `enable` in 1: game running level from the top-level FSM.
- `frame_tick` in 1: one-cycle pulse per video frame.
- `wall_ready` in NUM_WALLS: per slot, 1 = wall idle and launchable.
- `wall_passed` in NUM_WALLS: per slot, one-cycle pulse when that wall leaves the screen uncollided.
- `wall_touched` in NUM_WALLS: per slot level, wall overlaps the player.
- `go` out NUM_WALLS: registered one-hot launch pulse, 1 cycle wide.
- `game_over` out 1: registered; high while in S_OVER.
- `score` out SCORE_W: walls cleared since the last game start.
- `active` out 1: high in S_COUNT or S_SPAWN.

## Operation
- States: S_IDLE, S_COUNT, S_SPAWN, S_OVER.
- Reset values: state S_IDLE, `go`=0, `game_over`=0, `score`=0, `active`=0, spawn counter=0, round-robin pointer=0.

State transitions:
- **S_IDLE**
  - `enable`=1 -> S_SPAWN. `score` is cleared to 0 and the pointer to 0 on this transition.
  - Otherwise stay.
- **S_SPAWN** (exactly one cycle)
  - Search `wall_ready` starting at the pointer index and wrapping modulo NUM_WALLS.
  - First ready slot k: `go[k]` is set for the next cycle and the pointer becomes (k+1) mod NUM_WALLS.
  - No ready slot: no `go`, pointer unchanged (missed launch, no retry).
  - Spawn counter loads the reload value. Next state S_COUNT.
- **S_COUNT**
  - Each `frame_tick` decrements the counter.
  - `frame_tick` with counter==1 -> S_SPAWN.
- **Any non-IDLE state**
  - `enable`=0 -> S_IDLE; `score` is held.
  - In S_COUNT or S_SPAWN, any bit of `wall_touched` -> S_OVER.
  - Priority: `enable`=0 over touched over spawn.
- **S_OVER**
  - `game_over`=1, no `go` issued, `score` frozen.
  - Leaves only when `enable`=0 -> S_IDLE.

Score:
- Increments by popcount(`wall_passed`) each cycle in S_COUNT or S_SPAWN.
- Saturates at 2^SCORE_W-1.
- `wall_passed` is ignored in S_IDLE and S_OVER.

Collision vs. score in the same cycle:
- Touched and passed in the same cycle: the collision wins and that cycle's passes are not counted.

## Timing
- `go` latency:
  - `frame_tick` with counter==1 sampled at edge N -> S_SPAWN during cycle N+1 -> `go` high during cycle N+2 only.
  - First launch after `enable` rises at edge N: `go` high in cycle N+2.
- `wall_ready` is sampled only in the S_SPAWN cycle.
- `go` is never asserted for a slot whose `wall_ready` was 0 in that cycle.
- `go` is at most one-hot and never high two consecutive cycles.
- Launch interval is the reload value in frame ticks. `frame_tick` during S_SPAWN is ignored.
- Collision: `wall_touched` at edge N -> `game_over`=1 from cycle N+1.
  - A `go` already registered for cycle N+1 is suppressed (forced 0).
- `score` updates one cycle after the `wall_passed` pulse.
- `reset` mid-game: all outputs return to reset values immediately (asynchronous), including an in-flight `go`.

## Configuration
- `WALL_SCHED_SPEEDUP_EN` defined: reload value = max(SPAWN_PERIOD - (score >> 3), SPAWN_PERIOD/2).
  - Launches speed up by one frame every 8 points, floored at half the period.
  - Reload uses the `score` value in the S_SPAWN cycle.
- Not defined: reload value is constantly SPAWN_PERIOD; the speed-up logic is absent.

## Test plan
- Reset, `enable`=1 at edge 10, all `wall_ready`=1 -> `go`=0001 in cycle 12; after 60 `frame_tick`s `go`=0010, then 0100, 1000, 0001 (round-robin wrap).
- `wall_ready`=1010, pointer=0 at spawn -> `go`=0010 and pointer 2. Next spawn with `wall_ready`=0000 -> no `go`, pointer stays 2.
- `wall_passed`=0011 in one cycle, then 0100 -> `score` 0->2->3. With SCORE_W=2 forced to 3, a further pass keeps `score`=3.
- `wall_touched[2]`=1 in the cycle before a pending `go` -> `game_over`=1 next cycle and `go` stays 0. `enable` low -> S_IDLE, `score` held. `enable` high -> `score`=0.
- `wall_touched` and `wall_passed` both asserted in one cycle -> `game_over`=1, `score` unchanged.
- With `WALL_SCHED_SPEEDUP_EN` and `score`=16 -> spawn interval 58 ticks. With `score`=255 -> interval 30 ticks.
